regbank_rr_arbiter: RTL and testbench
=====================================

// Module: regbank_rr_arbiter
// PURPOSE
//  Shares one 16x32 general register bank between NREQ requesters (decode, DMA, debug, ...).
//  Round-robin arbitration; one access (read or write) per grant; req/gnt/ack handshake.
//  Sits between the instruction-decode field extractors and the register storage.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  AW     4   register address width
//  DW     32  register data width
//  DEPTH  16  registers implemented (<= 2**AW)
// PORTS
//  clk    in   1        single clock, all state on posedge
//  rst    in   1        asynchronous, active-high reset
//  req    in   NREQ     per-requester access request, level
//  we     in   NREQ     per-requester write enable (1=write, 0=read)
//  addr   in   NREQ*AW  per-requester register index, requester i at [i*AW +: AW]
//  wdata  in   NREQ*DW  per-requester write data, requester i at [i*DW +: DW]
//  gnt    out  NREQ     one-hot grant, registered
//  ack    out  NREQ     one-hot single-cycle completion pulse, registered
//  rdata  out  DW       read data (write: echoes written value); valid when any ack=1
//  busy   out  1        1 whenever state != IDLE
// BEHAVIOUR
//  Reset: gnt=0, ack=0, rdata=0, busy=0, state=IDLE, rr pointer=0, all registers=0.
//  FSM IDLE -> GRANT -> ACK -> IDLE; no other states; illegal encodings -> IDLE.
//  IDLE: if |req, pick first set req scanning ptr, ptr+1, ... mod NREQ; latch winner's
//   we/addr/wdata and winner index; -> GRANT. If no req, stay IDLE, outputs 0.
//  GRANT (1 cycle): gnt[winner]=1, busy=1; bank access performed with latched fields
//   (write commits at end of this cycle; read samples bank contents at this cycle).
//  ACK (1 cycle): gnt=0, ack[winner]=1, rdata valid; ptr <= winner+1 mod NREQ; -> IDLE.
//  Latency: req sampled at cycle T -> gnt at T+1 -> ack at T+2; max throughput 1 per 3 cycles.
//  Requester dropping req after T: access still completes, ack still issued.
//  Requester holding req after ack: re-arbitrated; waits behind any other pending req.
//  All req asserted continuously from reset: grant order 0,1,2,...,NREQ-1,0,...
//  Starvation bound: pending requester served within NREQ grants.
//  Read after write to same index by a later grant returns the new value.
//  addr >= DEPTH: write ignored, read returns 0; ack still issued.
//  rdata holds its last value outside ack cycles (only defined when ack=1).
//  Reset mid-operation (any state): immediate return to reset values; no ack emitted,
//   in-flight write discarded if not yet committed.
//  gnt and ack never both nonzero in the same cycle; each is one-hot or zero.
// STRUCTURE
//  regbank_pkg: state encoding (ST_IDLE/ST_GRANT/ST_ACK), default AW/DW/DEPTH constants.
//  Sub-module regbank_rf: DEPTH x DW storage, one sync write port, one read port,
//   async reset clears contents; arbiter owns FSM, pointer, operand latches.
//  Round-robin pick as a function (rotate, priority-encode, rotate back).
// TESTING
//  1 Reset: rst pulse mid-GRANT with write pending -> gnt=ack=0, busy=0, target reg reads 0.
//  2 Single write then read: req0 we=1 addr=5 wdata=32'hDEAD_BEEF -> gnt[0]@T+1, ack[0]@T+2;
//    then req0 we=0 addr=5 -> ack[0] with rdata=32'hDEAD_BEEF.
//  3 Fairness: req=4'b1111 held 12 grants -> ack order 0,1,2,3,0,1,2,3,0,1,2,3.
//  4 Pointer skip: after grant to 1, req=4'b0011 -> next grant 0 (not 1 again); then 1.
//  5 Early drop: req2 asserted one cycle only, we=1 addr=3 data=7 -> ack[2]@T+2, reg3=7.
//  6 Out of range (DEPTH=12): write addr=14 data=1 then read addr=14 -> ack, rdata=0.
//  All: assert gnt/ack one-hot-or-zero, never overlapping, busy==(state!=IDLE).

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and defaults for the round-robin register-bank arbiter.
// Holds the FSM encoding and the rotate/priority-encode/rotate-back pick function.
package regbank_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StAck   = 2'd2
    } state_e;

    localparam int unsigned DefAw    = 4;
    localparam int unsigned DefDw    = 32;
    localparam int unsigned DefDepth = 16;
    localparam int unsigned MaxReq   = 8;
    localparam int unsigned IdxW     = 3;

    // Winner = first set bit of req starting at ptr, wrapping modulo nreq.
    function automatic logic [IdxW-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                 input logic [IdxW-1:0]   ptr,
                                                 input int unsigned       nreq);
        logic [MaxReq-1:0] rot;
        int unsigned       k;
        rot = '0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            if (i < nreq) begin
                rot[i] = req[IdxW'((32'(ptr) + i) % nreq)];
            end
        end
        k = 0;
        for (int unsigned i = MaxReq; i > 0; i--) begin
            if (rot[i-1]) begin
                k = i - 1;
            end
        end
        return IdxW'((32'(ptr) + k) % nreq);
    endfunction

endpackage

// File: rtl/regbank_rf.sv
// DEPTH x DW register storage: one synchronous write port, one combinational read port.
// Indices at or beyond DEPTH are ignored on write and read back as zero.
module regbank_rf
    import regbank_pkg::*;
#(
    parameter int unsigned AW    = DefAw,
    parameter int unsigned DW    = DefDw,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic          waddr_ok;
    logic          raddr_ok;

    assign waddr_ok = {1'b0, waddr_i} < DepthW;
    assign raddr_ok = {1'b0, raddr_i} < DepthW;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && waddr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = raddr_ok ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/regbank_rr_arbiter.sv
// Round-robin arbiter sharing one register bank among NREQ requesters.
// Each grant performs one read or write: IDLE -> GRANT -> ACK -> IDLE.
module regbank_rr_arbiter
    import regbank_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned AW    = DefAw,
    parameter int unsigned DW    = DefDw,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    ack_o,
    output logic [DW-1:0]      rdata_o,
    output logic               busy_o
);

    localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

    state_e            state_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   win_q;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   ack_q;
    logic [DW-1:0]     rdata_q;

    logic [MaxReq-1:0] req_ext;
    logic [MaxReq-1:0] we_ext;
    logic [AW-1:0]     addr_arr  [MaxReq];
    logic [DW-1:0]     wdata_arr [MaxReq];
    logic [IdxW-1:0]   pick;
    logic              rf_we;
    logic [DW-1:0]     rf_rdata;

    assign req_ext = MaxReq'(req_i);
    assign we_ext  = MaxReq'(we_i);

    // Unpack per-requester fields so the winner can be selected by index.
    for (genvar g = 0; g < MaxReq; g++) begin : g_unpack
        if (g < NREQ) begin : g_live
            assign addr_arr[g]  = addr_i[g*AW +: AW];
            assign wdata_arr[g] = wdata_i[g*DW +: DW];
        end else begin : g_pad
            assign addr_arr[g]  = '0;
            assign wdata_arr[g] = '0;
        end
    end

    assign pick = rr_pick(req_ext, ptr_q, NREQ);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            win_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    ack_q <= '0;
                    gnt_q <= '0;
                    if (|req_i) begin
                        win_q   <= pick;
                        we_q    <= we_ext[pick];
                        addr_q  <= addr_arr[pick];
                        wdata_q <= wdata_arr[pick];
                        gnt_q   <= OneHot0 << pick;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    gnt_q   <= '0;
                    ack_q   <= OneHot0 << win_q;
                    rdata_q <= we_q ? wdata_q : rf_rdata;
                    ptr_q   <= IdxW'((32'(win_q) + 1) % NREQ);
                    state_q <= StAck;
                end
                StAck: begin
                    ack_q   <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Write commits on the edge that ends GRANT; the read is sampled on that same edge.
    assign rf_we = (state_q == StGrant) && we_q;

    regbank_rf #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_rf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (rf_we),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (addr_q),
        .rdata_o (rf_rdata)
    );

    assign gnt_o   = gnt_q;
    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_regbank_rr_arbiter.sv
// Directed bench for regbank_rr_arbiter: reset, read/write, fairness, pointer skip,
// early request drop and out-of-range indices, with per-cycle handshake invariants.
module tb_regbank_rr_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   we;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   gnt;
    logic [3:0]   ack;
    logic [31:0]  rdata;
    logic         busy;

    int total = 0;
    int bad   = 0;

    regbank_rr_arbiter #(
        .NREQ  (4),
        .AW    (4),
        .DW    (32),
        .DEPTH (12)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .gnt_o   (gnt),
        .ack_o   (ack),
        .rdata_o (rdata),
        .busy_o  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_field(input int idx, input logic w, input logic [3:0] a,
                             input logic [31:0] d);
        we[idx]          = w;
        addr[idx*4 +: 4] = a;
        wdata[idx*32 +: 32] = d;
    endtask

    // Lone requester: request for one cycle, expect grant then ack with exp_rd.
    task automatic do_access(input string tag, input int idx, input logic w,
                             input logic [3:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd);
        set_field(idx, w, a, d);
        req[idx] = 1'b1;
        tick();
        chk({tag, "_gnt"}, 32'(gnt), 32'(1) << idx);
        chk({tag, "_busy_g"}, 32'(busy), 32'd1);
        req[idx] = 1'b0;
        tick();
        chk({tag, "_ack"}, 32'(ack), 32'(1) << idx);
        chk({tag, "_rdata"}, rdata, exp_rd);
        tick();
        chk({tag, "_idle"}, {31'd0, busy} | 32'(ack) | 32'(gnt), 32'd0);
    endtask

    // Handshake invariants sampled away from the active edge.
    always @(negedge clk) begin : inv
        logic ok;
        if (!rst) begin
            ok = $onehot0(gnt) && $onehot0(ack) && ((gnt & ack) == 4'b0)
                 && (busy == ((|gnt) || (|ack)));
            total++;
            assert (ok) else begin
                bad++;
                $error("FAIL invariant observed gnt=%b ack=%b busy=%b expected onehot0/disjoint",
                       gnt, ack, busy);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Reset during GRANT with a write pending: write must be discarded.
        set_field(0, 1'b1, 4'd7, 32'hAAAA_5555);
        req[0] = 1'b1;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        #1;
        chk("t1_rst_gnt", 32'(gnt), 32'd0);
        chk("t1_rst_ack", 32'(ack), 32'd0);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        req[0] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        do_access("t1_rd", 0, 1'b0, 4'd7, 32'd0, 32'd0);

        // Single write then read.
        do_access("t2_wr", 0, 1'b1, 4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_access("t2_rd", 0, 1'b0, 4'd5, 32'd0, 32'hDEAD_BEEF);
        tick();
        tick();
        chk("t2_hold", rdata, 32'hDEAD_BEEF);

        // Fairness from a fresh reset with all requesters asserted.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_field(i, 1'b0, 4'(i), 32'd0);
        req = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("t3_gnt", 32'(gnt), 32'(1) << (k % 4));
            tick();
            chk("t3_ack", 32'(ack), 32'(1) << (k % 4));
            tick();
        end
        req = '0;

        // Pointer skip: after grant to 1, {1,0} pending -> 0 first, then 1.
        do_access("t4_one", 1, 1'b0, 4'd1, 32'd0, 32'd0);
        set_field(0, 1'b0, 4'd0, 32'd0);
        set_field(1, 1'b0, 4'd0, 32'd0);
        req = 4'b0011;
        tick();
        chk("t4_gnt0", 32'(gnt), 32'h1);
        tick();
        chk("t4_ack0", 32'(ack), 32'h1);
        tick();
        tick();
        chk("t4_gnt1", 32'(gnt), 32'h2);
        req = '0;
        tick();
        chk("t4_ack1", 32'(ack), 32'h2);
        tick();

        // Early drop of req2, then read back through another requester.
        do_access("t5_wr", 2, 1'b1, 4'd3, 32'd7, 32'd7);
        do_access("t5_rd", 1, 1'b0, 4'd3, 32'd0, 32'd7);

        // Out-of-range indices with DEPTH=12, and the last valid index.
        do_access("t6_wr14", 3, 1'b1, 4'd14, 32'd1, 32'd1);
        do_access("t6_rd14", 3, 1'b0, 4'd14, 32'd0, 32'd0);
        do_access("t6_wr11", 0, 1'b1, 4'd11, 32'h1234, 32'h1234);
        do_access("t6_rd11", 2, 1'b0, 4'd11, 32'd0, 32'h1234);
        do_access("t6_wr12", 1, 1'b1, 4'd12, 32'd5, 32'd5);
        do_access("t6_rd12", 1, 1'b0, 4'd12, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
